// File: rtl/register_file_param_if.sv
// Register-file access bundle: two read ports, one write port, busy scoreboard set,
// and the registered read results.
interface register_file_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              we;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_reg;
    logic [DATA_W-1:0] rs_out;
    logic [DATA_W-1:0] rt_out;
    logic              rs_busy;
    logic              rt_busy;
    logic              out_valid;

    modport master (
        output rd_en, rs, rt, we, writeReg, writeData, busy_set, busy_reg,
        input  rs_out, rt_out, rs_busy, rt_busy, out_valid
    );

    modport slave (
        input  rd_en, rs, rt, we, writeReg, writeData, busy_set, busy_reg,
        output rs_out, rt_out, rs_busy, rt_busy, out_valid
    );
endinterface

// File: rtl/register_file_param.sv
// Parametrised 2R/1W register file with registered, write-first reads and a
// per-register busy scoreboard for pending writebacks.
module register_file_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    register_file_param_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;
    logic              bs_ok;
    logic              rs_ok;
    logic              rt_ok;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              rs_bnxt;
    logic              rt_bnxt;

    // An index is live if it exists and is not the hardwired zero register.
    function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    always_comb begin
        wr_ok = bus.we && idx_ok(bus.writeReg);
        bs_ok = bus.busy_set && idx_ok(bus.busy_reg);
        rs_ok = idx_ok(bus.rs);
        rt_ok = idx_ok(bus.rt);
    end

    // Set is applied after clear so a new producer overrides a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[idx(bus.writeReg)] = 1'b0;
        if (bs_ok) busy_nxt[idx(bus.busy_reg)] = 1'b1;
    end

    always_comb begin
        rs_val  = '0;
        rt_val  = '0;
        rs_bnxt = 1'b0;
        rt_bnxt = 1'b0;
        if (rs_ok) begin
            rs_val  = (wr_ok && (bus.writeReg == bus.rs)) ? bus.writeData : mem[idx(bus.rs)];
            rs_bnxt = busy_nxt[idx(bus.rs)];
        end
        if (rt_ok) begin
            rt_val  = (wr_ok && (bus.writeReg == bus.rt)) ? bus.writeData : mem[idx(bus.rt)];
            rt_bnxt = busy_nxt[idx(bus.rt)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[idx(bus.writeReg)] <= bus.writeData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy          <= '0;
            bus.rs_out    <= '0;
            bus.rt_out    <= '0;
            bus.rs_busy   <= 1'b0;
            bus.rt_busy   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            busy          <= busy_nxt;
            bus.out_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rs_out  <= rs_val;
                bus.rt_out  <= rt_val;
                bus.rs_busy <= rs_bnxt;
                bus.rt_busy <= rt_bnxt;
            end
        end
    end
endmodule

// File: tb/tb_register_file_param.sv
// Directed bench: default 32x32 register file plus a 16-bit, 8-deep, 4-bit-index variant.
module tb_register_file_param;
    logic clk;
    logic rst;
    int   ncmp;
    int   nfail;

    register_file_param_if #(.DATA_W(32), .ADDR_W(5)) b ();
    register_file_param_if #(.DATA_W(16), .ADDR_W(4)) s ();

    register_file_param #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1'b1)
    ) dut_big (
        .clk(clk), .rst(rst), .bus(b)
    );

    register_file_param #(
        .DATA_W(16), .ADDR_W(4), .DEPTH(8), .ZERO_REG(1'b1)
    ) dut_small (
        .clk(clk), .rst(rst), .bus(s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b.rd_en = 1'b0; b.rs = '0; b.rt = '0; b.we = 1'b0;
        b.writeReg = '0; b.writeData = '0; b.busy_set = 1'b0; b.busy_reg = '0;
        s.rd_en = 1'b0; s.rs = '0; s.rt = '0; s.we = 1'b0;
        s.writeReg = '0; s.writeData = '0; s.busy_set = 1'b0; s.busy_reg = '0;
    endtask

    // Let one rising edge sample the current inputs, then move just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        rst   = 1'b0;
        idle();
        step();
        step();
        chk("reset_rs_out", b.rs_out, 32'h0);
        chk("reset_rt_out", b.rt_out, 32'h0);
        chk("reset_valid", 32'(b.out_valid), 32'h0);
        chk("reset_rs_busy", 32'(b.rs_busy), 32'h0);
        chk("reset_small_out", 32'(s.rs_out), 32'h0);

        rst = 1'b1;
        b.we = 1'b1; b.writeReg = 5'd5; b.writeData = 32'hDEADBEEF;
        step();
        idle();
        b.rd_en = 1'b1; b.rs = 5'd5; b.rt = 5'd5;
        step();
        chk("pre_reset_rs_out", b.rs_out, 32'hDEADBEEF);
        chk("pre_reset_valid", 32'(b.out_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_rs_out", b.rs_out, 32'h0);
        chk("async_reset_valid", 32'(b.out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_reset_r5", b.rs_out, 32'h0);
        chk("post_reset_valid", 32'(b.out_valid), 32'h1);

        idle();
        b.we = 1'b1; b.writeReg = 5'd7; b.writeData = 32'h12345678;
        step();
        idle();
        b.rd_en = 1'b1; b.rs = 5'd7; b.rt = 5'd7;
        step();
        chk("basic_rs_out", b.rs_out, 32'h12345678);
        chk("basic_rt_out", b.rt_out, 32'h12345678);
        chk("basic_valid", 32'(b.out_valid), 32'h1);
        idle();
        b.rs = 5'd1;
        step();
        chk("hold_valid_low", 32'(b.out_valid), 32'h0);
        chk("hold_rs_out", b.rs_out, 32'h12345678);

        b.we = 1'b1; b.writeReg = 5'd9; b.writeData = 32'hA5A5A5A5;
        b.rd_en = 1'b1; b.rs = 5'd9; b.rt = 5'd7;
        step();
        chk("bypass_rs_out", b.rs_out, 32'hA5A5A5A5);
        chk("bypass_rt_out", b.rt_out, 32'h12345678);

        idle();
        b.we = 1'b1; b.writeReg = 5'd0; b.writeData = 32'hFFFFFFFF;
        b.busy_set = 1'b1; b.busy_reg = 5'd0;
        step();
        idle();
        b.rd_en = 1'b1; b.rs = 5'd0; b.rt = 5'd9;
        step();
        chk("zero_rs_out", b.rs_out, 32'h0);
        chk("zero_rs_busy", 32'(b.rs_busy), 32'h0);
        chk("r9_retained", b.rt_out, 32'hA5A5A5A5);

        idle();
        b.busy_set = 1'b1; b.busy_reg = 5'd3;
        step();
        idle();
        b.rd_en = 1'b1; b.rs = 5'd3; b.rt = 5'd7;
        step();
        chk("busy_set_r3", 32'(b.rs_busy), 32'h1);
        chk("busy_other_clear", 32'(b.rt_busy), 32'h0);
        idle();
        b.we = 1'b1; b.writeReg = 5'd3; b.writeData = 32'h00000033;
        b.rd_en = 1'b1; b.rs = 5'd3;
        step();
        chk("busy_cleared_r3", 32'(b.rs_busy), 32'h0);
        chk("busy_clear_data", b.rs_out, 32'h00000033);
        idle();
        b.we = 1'b1; b.writeReg = 5'd3; b.writeData = 32'h00000044;
        b.busy_set = 1'b1; b.busy_reg = 5'd3;
        b.rd_en = 1'b1; b.rs = 5'd3; b.rt = 5'd3;
        step();
        chk("set_wins_rs_busy", 32'(b.rs_busy), 32'h1);
        chk("set_wins_rt_busy", 32'(b.rt_busy), 32'h1);
        chk("set_wins_data", b.rs_out, 32'h00000044);

        idle();
        s.we = 1'b1; s.writeReg = 4'd12; s.writeData = 16'h1234;
        s.busy_set = 1'b1; s.busy_reg = 4'd12;
        step();
        idle();
        s.we = 1'b1; s.writeReg = 4'd7; s.writeData = 16'hBEEF;
        step();
        idle();
        s.rd_en = 1'b1; s.rs = 4'd12; s.rt = 4'd7;
        step();
        chk("small_r12_out", 32'(s.rs_out), 32'h0);
        chk("small_r12_busy", 32'(s.rs_busy), 32'h0);
        chk("small_r7_out", 32'(s.rt_out), 32'h0000BEEF);
        chk("small_valid", 32'(s.out_valid), 32'h1);
        idle();
        s.rd_en = 1'b1; s.rs = 4'd4; s.rt = 4'd7;
        step();
        chk("small_alias_r4", 32'(s.rs_out), 32'h0);

        idle();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
